// File: rtl/npc_ras.sv
// ---------------------------------------------------------------------------
// npc_ras : next-PC unit with a circular return-address stack (RAS)
//
// Owns the PC register and selects the next PC from jump-register, jump and
// conditional-branch controls. A small circular RAS records the return
// address of every linking call. It predicts the target of `jr $ra` and
// counts how often that prediction is wrong. The RAS never steers next_pc:
// it only predicts and collects statistics.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   synchronous reset, active low
//   stall          in   hold PC, RAS and counters
//   ras_clear      in   flush the RAS (count and pointer to 0)
//   instr          in   current instruction word
//   busA           in   rs register value (jr target / branch compare)
//   Branch         in   branch type code
//   Zero           in   ALU zero flag
//   Jump           in   j / jal
//   Jreg           in   jr / jalr
//   Link           in   jal / jalr, push the return address
//   pc             out  current PC register
//   pc_add4        out  pc + 4
//   next_pc        out  PC loaded on the next unstalled edge
//   ras_pred       out  top RAS entry, 0 when empty
//   ras_pred_valid out  RAS holds at least one entry
//   ras_miss       out  one-cycle pulse after a mispredicted return
//   ret_cnt        out  saturating count of executed `jr $ra`
//   miss_cnt       out  saturating count of mispredicted returns
// ---------------------------------------------------------------------------
module npc_ras #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(32'h0000_3000),
  parameter int               RAS_DEPTH = 4,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ras_clear,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  busA,
  input  logic [3:0]       Branch,
  input  logic             Zero,
  input  logic             Jump,
  input  logic             Jreg,
  input  logic             Link,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_add4,
  output logic [XLEN-1:0]  next_pc,
  output logic [XLEN-1:0]  ras_pred,
  output logic             ras_pred_valid,
  output logic             ras_miss,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_RW = PTR_W + 1;   // entry count needs to reach RAS_DEPTH

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [CNT_RW-1:0] r_cnt;
  logic              r_miss;
  logic [CNT_W-1:0]  r_ret_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  // -------------------------------------------------------------------------
  // Next-PC datapath
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] w_pc_add4;
  logic [XLEN-1:0] w_imm_ext;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_j_target;
  logic            w_busa_neg;
  logic            w_busa_zero;
  logic            w_br_taken;
  logic [XLEN-1:0] w_next_pc;

  assign w_pc_add4   = r_pc + XLEN'(4);
  assign w_imm_ext   = {{(XLEN-16){instr[15]}}, instr[15:0]};
  assign w_br_target = w_pc_add4 + (w_imm_ext << 2);
  assign w_j_target  = {w_pc_add4[XLEN-1:28], instr[25:0], 2'b00};

  // Signed comparisons against zero reduce to the sign bit and a zero test.
  assign w_busa_neg  = busA[XLEN-1];
  assign w_busa_zero = (busA == '0);

  always_comb begin
    w_br_taken = 1'b0;
    case (Branch)
      4'b0001: w_br_taken = Zero;                          // beq
      4'b0011: w_br_taken = !Zero;                         // bne
      4'b0101: w_br_taken = !w_busa_neg && !w_busa_zero;   // bgtz
      4'b0111: w_br_taken = !w_busa_neg;                   // bgez
      4'b1001: w_br_taken = w_busa_neg;                    // bltz
      4'b1011: w_br_taken = w_busa_neg || w_busa_zero;     // blez
      default: w_br_taken = 1'b0;
    endcase
  end

  always_comb begin
    if (Jreg)            w_next_pc = busA;
    else if (Jump)       w_next_pc = w_j_target;
    else if (w_br_taken) w_next_pc = w_br_target;
    else                 w_next_pc = w_pc_add4;
  end

  // -------------------------------------------------------------------------
  // Return-address stack control
  // -------------------------------------------------------------------------
  logic              w_ras_empty;
  logic [XLEN-1:0]   w_top_entry;
  logic              w_ret;
  logic              w_push;
  logic              w_ret_miss;
  logic [PTR_W-1:0]  w_top_next;
  logic [CNT_RW-1:0] w_cnt_next;
  logic [PTR_W-1:0]  w_push_idx;

  assign w_ras_empty = (r_cnt == '0);
  assign w_top_entry = r_ras[r_top];
  assign w_ret       = Jreg && (instr[25:21] == 5'd31) && !stall;
  assign w_push      = Link && !stall;
  // An empty stack has nothing to predict, so the return is a miss.
  assign w_ret_miss  = w_ret && (w_ras_empty || (w_top_entry != busA));

  // Pop is applied before push so jalr $31,$31 replaces the top entry.
  always_comb begin
    w_top_next = r_top;
    w_cnt_next = r_cnt;
    if (w_ret && !w_ras_empty) begin
      w_top_next = r_top - PTR_W'(1);
      w_cnt_next = r_cnt - CNT_RW'(1);
    end
    w_push_idx = w_top_next + PTR_W'(1);
    if (w_push) begin
      w_top_next = w_push_idx;
      // When full the oldest slot is overwritten and the count saturates.
      if (w_cnt_next != CNT_RW'(RAS_DEPTH)) w_cnt_next = w_cnt_next + CNT_RW'(1);
    end
    if (ras_clear) begin
      w_top_next = '0;
      w_cnt_next = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_top      <= '0;
      r_cnt      <= '0;
      r_miss     <= 1'b0;
      r_ret_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      // w_ret/w_push already include !stall, so only the PC needs gating here.
      if (!stall) r_pc <= w_next_pc;
      r_top  <= w_top_next;
      r_cnt  <= w_cnt_next;
      r_miss <= w_ret_miss;
      if (w_ret && (r_ret_cnt != '1))
        r_ret_cnt <= r_ret_cnt + CNT_W'(1);
      if (w_ret_miss && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  // Entry storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && w_push && !ras_clear)
      r_ras[w_push_idx] <= w_pc_add4;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pc             = r_pc;
  assign pc_add4        = w_pc_add4;
  assign next_pc        = w_next_pc;
  assign ras_pred_valid = !w_ras_empty;
  assign ras_pred       = w_ras_empty ? '0 : w_top_entry;
  assign ras_miss       = r_miss;
  assign ret_cnt        = r_ret_cnt;
  assign miss_cnt       = r_miss_cnt;

endmodule

// File: tb/tb_npc_ras.sv
// ---------------------------------------------------------------------------
// tb_npc_ras : directed self-checking bench for npc_ras
//
// Walks reset, branch/jump selection, matched call/return, RAS overflow,
// stall, jalr replacement and flush, with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_npc_ras;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        ras_clear;
  logic [31:0] instr;
  logic [31:0] busA;
  logic [3:0]  Branch;
  logic        Zero;
  logic        Jump;
  logic        Jreg;
  logic        Link;
  logic [31:0] pc;
  logic [31:0] pc_add4;
  logic [31:0] next_pc;
  logic [31:0] ras_pred;
  logic        ras_pred_valid;
  logic        ras_miss;
  logic [15:0] ret_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] JR_RA   = 32'h03E0_0008;  // jr $31
  localparam logic [31:0] JALR_RA = 32'h03E0_F809;  // jalr $31,$31

  npc_ras dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .ras_clear      (ras_clear),
    .instr          (instr),
    .busA           (busA),
    .Branch         (Branch),
    .Zero           (Zero),
    .Jump           (Jump),
    .Jreg           (Jreg),
    .Link           (Link),
    .pc             (pc),
    .pc_add4        (pc_add4),
    .next_pc        (next_pc),
    .ras_pred       (ras_pred),
    .ras_pred_valid (ras_pred_valid),
    .ras_miss       (ras_miss),
    .ret_cnt        (ret_cnt),
    .miss_cnt       (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle past it before looking at outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; ras_clear = 1'b0; instr = 32'h0; busA = 32'h0;
    Branch = 4'b0000; Zero = 1'b0; Jump = 1'b0; Jreg = 1'b0; Link = 1'b0;
  endtask

  task automatic jal(input logic [25:0] tgt);
    idle();
    instr = {6'h03, tgt}; Jump = 1'b1; Link = 1'b1;
  endtask

  task automatic jr_ra(input logic [31:0] target);
    idle();
    instr = JR_RA; Jreg = 1'b1; busA = target;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    stall = 1'b1;

    // ---------------- reset ----------------
    step(); step();
    chk("rst_pc",       pc,                    32'h3000);
    chk("rst_valid",    {31'b0, ras_pred_valid}, 32'h0);
    chk("rst_ret_cnt",  {16'b0, ret_cnt},      32'h0);
    chk("rst_miss_cnt", {16'b0, miss_cnt},     32'h0);
    chk("rst_ras_miss", {31'b0, ras_miss},     32'h0);

    rst_n = 1'b1;
    idle();
    #1;
    chk("seq_next0", next_pc, 32'h3004);
    step(); chk("seq_pc1", pc, 32'h3004);
    step(); chk("seq_pc2", pc, 32'h3008);
    step(); step();
    chk("seq_pc4", pc, 32'h3010);

    // ---------------- branches at pc=3010 ----------------
    instr = 32'h1000_FFFE; Branch = 4'b0001; Zero = 1'b1; #1;
    chk("beq_taken", next_pc, 32'h300C);
    Zero = 1'b0; #1;
    chk("beq_not", next_pc, 32'h3014);
    Branch = 4'b0011; #1;
    chk("bne_taken", next_pc, 32'h300C);
    Branch = 4'b0101; busA = 32'h0; #1;
    chk("bgtz_zero", next_pc, 32'h3014);
    Branch = 4'b0111; #1;
    chk("bgez_zero", next_pc, 32'h300C);
    Branch = 4'b1001; busA = 32'h8000_0000; #1;
    chk("bltz_min", next_pc, 32'h300C);
    Branch = 4'b1011; busA = 32'h1; #1;
    chk("blez_pos", next_pc, 32'h3014);
    Branch = 4'b0010; Zero = 1'b1; #1;
    chk("bad_code", next_pc, 32'h3014);
    Branch = 4'b0001; step();
    chk("beq_pc", pc, 32'h300C);
    idle();
    for (int i = 0; i < 5; i++) step();
    chk("pc_3020", pc, 32'h3020);

    // ---------------- jump / jump-register ----------------
    instr = {6'h02, 26'h0000C40}; Jump = 1'b1; #1;
    chk("j_target", next_pc, 32'h3100);
    Jreg = 1'b1; busA = 32'h3400; #1;
    chk("jr_prio", next_pc, 32'h3400);

    // ---------------- matched call / return ----------------
    idle();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst2_pc", pc, 32'h3000);
    jal(26'h0000C40); step();
    chk("jal_pc",    pc,                      32'h3100);
    chk("jal_valid", {31'b0, ras_pred_valid}, 32'h1);
    jr_ra(32'h3004); #1;
    chk("ret_pred", ras_pred, 32'h3004);
    step();
    chk("ret_pc",       pc,                32'h3004);
    chk("ret_ret_cnt",  {16'b0, ret_cnt},  32'h1);
    chk("ret_miss_cnt", {16'b0, miss_cnt}, 32'h0);
    chk("ret_ras_miss", {31'b0, ras_miss}, 32'h0);
    chk("ret_empty",    {31'b0, ras_pred_valid}, 32'h0);

    // ---------------- overflow: 5 pushes into a 4-deep RAS ----------------
    // Pushed: A1=3008, A2=4004, A3=4104, A4=4204, A5=4304; A1 is overwritten.
    for (int i = 0; i < 5; i++) begin
      jal(26'h1000 + 26'(i * 32'h40)); step();
    end
    chk("ovf_pc",   pc,       32'h4400);
    chk("ovf_pred", ras_pred, 32'h4304);
    jr_ra(32'h4304); #1; chk("pop_pred5", ras_pred, 32'h4304); step();
    chk("pop_miss5", {31'b0, ras_miss}, 32'h0);
    jr_ra(32'h4204); #1; chk("pop_pred4", ras_pred, 32'h4204); step();
    jr_ra(32'h4104); #1; chk("pop_pred3", ras_pred, 32'h4104); step();
    jr_ra(32'h4004); #1; chk("pop_pred2", ras_pred, 32'h4004); step();
    chk("pop_hits_miss_cnt", {16'b0, miss_cnt}, 32'h0);
    chk("pop_drained", {31'b0, ras_pred_valid}, 32'h0);
    jr_ra(32'h3008); #1; chk("pop_empty_pred", ras_pred, 32'h0); step();
    chk("under_miss_cnt", {16'b0, miss_cnt}, 32'h1);
    chk("under_ret_cnt",  {16'b0, ret_cnt},  32'h6);
    chk("under_pulse",    {31'b0, ras_miss}, 32'h1);
    chk("under_pc",       pc,                32'h3008);
    idle(); step();
    chk("under_pulse_end", {31'b0, ras_miss}, 32'h0);
    chk("pc_300C", pc, 32'h300C);

    // ---------------- stall during jal ----------------
    jal(26'h0000C40); stall = 1'b1; step();
    chk("stall_pc",    pc,                      32'h300C);
    chk("stall_valid", {31'b0, ras_pred_valid}, 32'h0);
    stall = 1'b0; step();
    chk("unstall_pc",   pc,       32'h3100);
    chk("unstall_pred", ras_pred, 32'h3010);
    jal(26'h1000); step();
    chk("jal2_pred", ras_pred, 32'h3104);

    // ---------------- jalr $31,$31 with count=2 ----------------
    idle(); instr = JALR_RA; Jreg = 1'b1; Link = 1'b1; busA = 32'h3104; step();
    chk("jalr_pc",       pc,                32'h3104);
    chk("jalr_pred",     ras_pred,          32'h4004);
    chk("jalr_ret_cnt",  {16'b0, ret_cnt},  32'h7);
    chk("jalr_miss_cnt", {16'b0, miss_cnt}, 32'h1);
    jr_ra(32'h4004); step();
    chk("jalr_depth_pred",  ras_pred,                32'h3010);
    chk("jalr_depth_valid", {31'b0, ras_pred_valid}, 32'h1);
    chk("jalr_hit_cnt",     {16'b0, miss_cnt},       32'h1);

    // ---------------- flush with simultaneous push ----------------
    jal(26'h0000C40); ras_clear = 1'b1; step();
    chk("clr_valid", {31'b0, ras_pred_valid}, 32'h0);
    chk("clr_pred",  ras_pred,                32'h0);
    chk("clr_pc",    pc,                      32'h3100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npc_ras.md
Name: npc_ras

Overview:
Next-generation next-PC unit for the MIPS CPU. It owns the PC register and computes the next PC from the branch, jump and jump-register controls. It adds a parametrised circular return-address stack (RAS) that predicts `jr $ra` targets and counts prediction outcomes. The unit sits between the control unit/register file and instruction memory, and is ready for a later pipelined front end.

Parameters:
- XLEN, 32, address/data width; must be >= 32.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- RAS_DEPTH, 4, number of RAS entries; a power of two, >= 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- stall  in  1  hold the PC and RAS; no state change.
- ras_clear  in  1  synchronous RAS flush; count goes to 0.
- instr  in  32  current instruction.
- busA  in  XLEN  rs register value.
- Branch  in  4  branch type code.
- Zero  in  1  ALU zero flag.
- Jump  in  1  j/jal.
- Jreg  in  1  jr/jalr.
- Link  in  1  jal/jalr; push the return address.
- pc  out  XLEN  current PC (register).
- pc_add4  out  XLEN  pc+4.
- next_pc  out  XLEN  PC to load on the next edge.
- ras_pred  out  XLEN  top RAS entry; 0 when empty.
- ras_pred_valid  out  1  RAS count != 0.
- ras_miss  out  1  registered one-cycle pulse on a mispredicted return.
- ret_cnt  out  CNT_W  number of `jr $ra` executed.
- miss_cnt  out  CNT_W  number of mispredicted returns.

Behaviour:
- Reset (clk edge with rst_n=0): pc=RESET_PC, RAS count=0, top pointer=0, ras_miss=0, ret_cnt=0, miss_cnt=0. Reset overrides stall and ras_clear.
- pc_add4 = pc+4, modulo 2^XLEN.
- Branch target = pc_add4 + (sign_ext(instr[15:0]) << 2), modulo 2^XLEN.
- Jump target = {pc_add4[XLEN-1:28], instr[25:0], 2'b00}.
- Branch taken conditions, with busA signed:
  - 4'b0001 beq: Zero.
  - 4'b0011 bne: !Zero.
  - 4'b0101 bgtz: busA > 0.
  - 4'b0111 bgez: busA >= 0.
  - 4'b1001 bltz: busA < 0.
  - 4'b1011 blez: busA <= 0.
  - Any other code: not taken.
- next_pc priority: Jreg -> busA; else Jump -> jump target; else branch taken -> branch target; else pc_add4. The RAS never changes next_pc; it is prediction and statistics only.
- Edge with rst_n=1 and stall=0: pc <= next_pc. Edge with stall=1: pc, RAS and counters hold, and ras_miss <= 0.
- Return event (ret) = Jreg && instr[25:21]==5'd31 && !stall.
- Pop on ret:
  - If count>0: compare the top entry to busA, then decrement count and move the top pointer back.
  - If count==0: no pop; the return counts as a miss.
- Push on Link && !stall: write pc_add4 at top+1 (mod RAS_DEPTH). If count<RAS_DEPTH, count+1; if full, the oldest entry is overwritten and count stays RAS_DEPTH.
- Simultaneous pop and push (jalr $31,$31): pop first, then push.
  - Net effect when count>0: top entry replaced, count unchanged.
  - When count==0: push only, count becomes 1.
- ras_clear=1 (not stalled or stalled): count <= 0 and the pointer resets. It takes precedence over push/pop in the same cycle. ret_cnt/miss_cnt still update for a ret in that cycle.
- Counters (saturating at 2^CNT_W-1):
  - ret_cnt increments on every ret.
  - miss_cnt increments on every ret that is empty or whose top entry != busA.
- ras_miss <= 1 for exactly the cycle after a missed ret, else 0.
- All outputs except pc/counters/ras_miss are combinational from the current state and inputs.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with stall=1 -> pc=32'h3000, ras_pred_valid=0, ret_cnt=miss_cnt=0. After release with all controls 0, pc steps 3000, 3004, 3008.
- Branches:
  - At pc=3010, Branch=0001, Zero=1, imm=16'hFFFE -> next_pc=300C.
  - Branch=0101 with busA=0 -> 3014.
  - Branch=1001 with busA=32'h8000_0000 -> taken.
- Jump/jreg: at pc=3020, Jump=1, instr[25:0]=26'h0000C40 -> next_pc=3100. With Jreg=1 and Jump=1, busA=3400 -> next_pc=3400.
- Matched call/return: jal at pc=3000 (push 3004), then jr $31 with busA=3004 -> ras_pred=3004 before the edge, ret_cnt=1, miss_cnt=0, ras_miss stays 0.
- Overflow: with RAS_DEPTH=4, execute 5 jal pushing A1..A5, then 5 returns with matching busA -> first four hit (A5..A2). The fifth sees an empty RAS: miss_cnt=1, ras_miss pulses for one cycle.
- Stall and flush:
  - stall=1 during jal -> pc and RAS unchanged.
  - jalr $31,$31 with count=2 -> count stays 2 and the top equals the new pc_add4.
  - ras_clear with a push in the same cycle -> count=0.
